// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the mic level meter.
//   SAMPLE_W / MIC_MID : offset-binary microphone sample format
//   LEVEL_W / LEVEL_MAX: published loudness magnitude format
//   meter_state_e      : two-state window FSM encoding
//   mic_mag()          : |sample - mid-scale| as a SAMPLE_W-bit unsigned
package audio_pkg;

    localparam int              SAMPLE_W  = 12;
    localparam logic [11:0]     MIC_MID   = 12'd2048;
    localparam int              LEVEL_W   = 20;
    localparam logic [19:0]     LEVEL_MAX = 20'hFFFFF;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_PUB = 1'b1
    } meter_state_e;

    // Mid-scale 2048 itself fits in 12 bits, so sample 0 maps to 2048 and
    // sample 4095 to 2047 without any extra width.
    function automatic logic [SAMPLE_W-1:0] mic_mag(input logic [SAMPLE_W-1:0] s);
        return (s >= MIC_MID) ? (s - MIC_MID) : (MIC_MID - s);
    endfunction

endpackage

// File: rtl/mic_level_meter_if.sv
// Sample-in / level-out bundle of the mic level meter.
//   sample_valid, sample : microphone samples (producer -> meter)
//   level, level_valid   : per-window saturated sum and its update pulse
//   peak                 : peak-hold / decay value, updated with level
// Modports: master = sample producer / level consumer, slave = meter.
interface mic_level_meter_if;

    logic                          sample_valid;
    logic [audio_pkg::SAMPLE_W-1:0] sample;
    logic [audio_pkg::LEVEL_W-1:0]  level;
    logic                          level_valid;
    logic [audio_pkg::LEVEL_W-1:0]  peak;

    modport master (
        output sample_valid, sample,
        input  level, level_valid, peak
    );

    modport slave (
        input  sample_valid, sample,
        output level, level_valid, peak
    );

endinterface

// File: rtl/mic_level_meter_peak_hold_decay.sv
// Peak-hold register with geometric decay.
//   clk, reset : clock and synchronous active-high reset
//   upd        : one-cycle strobe, a new window level is being published
//   L          : the new saturated window level
//   peak       : held / decaying peak value
// A new level at or above the peak captures it and re-arms the hold counter.
// While the counter is non-zero each window just counts it down; after that
// each window removes peak >> DECAY_SHIFT, never dropping below the new level.
module peak_hold_decay
    import audio_pkg::*;
#(
    parameter int HOLD_WINDOWS = 4,
    parameter int DECAY_SHIFT  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               upd,
    input  logic [LEVEL_W-1:0] L,
    output logic [LEVEL_W-1:0] peak
);

    logic [7:0]         hold_cnt;
    logic [LEVEL_W-1:0] decayed;

    // peak >> DECAY_SHIFT <= peak, so this cannot underflow. Below
    // 2^DECAY_SHIFT the decrement is zero and the peak stays put.
    assign decayed = peak - (peak >> DECAY_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            peak     <= '0;
            hold_cnt <= '0;
        end else if (upd) begin
            if (L >= peak) begin
                peak     <= L;
                hold_cnt <= 8'(HOLD_WINDOWS);
            end else if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end else begin
                peak <= (decayed < L) ? L : decayed;
            end
        end
    end

endmodule

// File: rtl/mic_level_meter.sv
// Microphone loudness meter.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mic_level_meter_if.slave
//                in : sample_valid, sample (offset-binary, mid-scale 2048)
//                out: level (saturated window sum of |sample-2048|),
//                     level_valid (one-cycle pulse per window), peak
// Window length is 2^LOG2_WIN accepted samples. The accumulator never stalls:
// on the last sample of a window the full sum is published straight into the
// level register and the accumulator restarts at zero, so a sample arriving
// in the following (PUB) cycle simply opens the next window.
module mic_level_meter
    import audio_pkg::*;
#(
    parameter int LOG2_WIN     = 8,
    parameter int HOLD_WINDOWS = 4,
    parameter int DECAY_SHIFT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    mic_level_meter_if.slave bus
);

    localparam int ACC_W = LOG2_WIN + SAMPLE_W;

    meter_state_e         state;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     sum;
    logic [LOG2_WIN-1:0]  sample_cnt;
    logic [SAMPLE_W-1:0]  mag;
    logic                 win_done;
    logic [LEVEL_W-1:0]   sum_sat;
    logic [LEVEL_W-1:0]   level_q;
    logic                 level_valid_q;
    logic [LEVEL_W-1:0]   peak_w;

    assign mag = mic_mag(bus.sample);

    // 2^LOG2_WIN samples of at most 2048 fit in ACC_W bits without wrap.
    assign sum = acc + ACC_W'(mag);

    // The last sample of the window is being accepted this cycle.
    assign win_done = bus.sample_valid && (sample_cnt == '1);

    generate
        if (ACC_W > LEVEL_W) begin : g_sat
            assign sum_sat = (sum > ACC_W'(LEVEL_MAX)) ? LEVEL_MAX : sum[LEVEL_W-1:0];
        end else begin : g_nosat
            assign sum_sat = LEVEL_W'(sum);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_ACC;
            acc           <= '0;
            sample_cnt    <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
        end else begin
            if (bus.sample_valid) begin
                sample_cnt <= sample_cnt + 1'b1;
                acc        <= win_done ? '0 : sum;
            end

            // Registered so level/level_valid/peak all land in the PUB cycle.
            level_valid_q <= win_done;
            if (win_done) begin
                level_q <= sum_sat;
            end

            case (state)
                ST_ACC:  if (win_done) state <= ST_PUB;
                ST_PUB:  state <= ST_ACC;
                default: state <= ST_ACC;
            endcase
        end
    end

    // Strobed on the edge that enters PUB so peak changes together with level.
    peak_hold_decay #(
        .HOLD_WINDOWS (HOLD_WINDOWS),
        .DECAY_SHIFT  (DECAY_SHIFT)
    ) u_peak (
        .clk   (clk),
        .reset (reset),
        .upd   (win_done),
        .L     (sum_sat),
        .peak  (peak_w)
    );

    assign bus.level       = level_q;
    assign bus.level_valid = level_valid_q;
    assign bus.peak        = peak_w;

endmodule

// File: doc/mic_level_meter.md
# mic_level_meter

Producer of the 20-bit loudness magnitude consumed by the bar-graph height scaler. Accepts offset-binary microphone samples with a valid strobe and sums their absolute deviation from mid-scale over a fixed window. Once per window it publishes a saturated 20-bit level with a one-cycle valid pulse. It also publishes a peak-hold value that holds for a programmable number of windows and then decays geometrically, so the LED bar can show a falling peak marker.

## Interface
- LOG2_WIN, 8: window length is 2^LOG2_WIN accepted samples (legal 4..12)
- HOLD_WINDOWS, 4: number of windows the peak is held before decay starts (legal 1..255)
- DECAY_SHIFT, 3: per-window decay is `peak >> DECAY_SHIFT` (legal 1..8)
- clk  in  1  system clock; one clock domain; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  qualifies `sample` for exactly one cycle
- sample  in  12  offset-binary mic sample; mid-scale = 2048
- level  out  20  last published window sum, saturated
- level_valid  out  1  one-cycle pulse when `level` and `peak` update
- peak  out  20  peak-hold/decay value

## Operation
- Magnitude is `mag = |sample − 2048|` and is 12 bits unsigned (sample 0 gives 2048; sample 4095 gives 2047).
- The accumulator is `LOG2_WIN+12` bits wide. `sample_cnt` is LOG2_WIN bits wide and counts accepted samples.
- States:
  - ACC: on `sample_valid`, `acc += mag` and `sample_cnt++`. When the last sample of the window is accepted (`sample_cnt` wraps to 0), the final sum is latched and the state goes to PUB.
  - PUB: lasts one cycle. `level` gets `min(sum, 2^20−1)`, `level_valid = 1`, the peak is updated, and the state returns to ACC.
- The accumulator restarts from 0 on the cycle the sum is latched.
- A `sample_valid` during PUB is not lost. It is accepted as the first sample of the next window, so the accumulator must be free to run while PUB is in progress.
- Peak update happens in PUB, using the new saturated level `L`:
  - If `L >= peak`: `peak = L` and `hold_cnt = HOLD_WINDOWS`.
  - Else if `hold_cnt != 0`: `hold_cnt--` and `peak` is unchanged.
  - Else: `peak = peak − (peak >> DECAY_SHIFT)`. If the result is below `L`, `peak = L` instead.
- Once the peak decays below `2^DECAY_SHIFT` it stays constant; the floor is reached only through `L`. This is accepted behaviour.
- No backpressure: the consumer must sample `level` and `peak` on `level_valid`, or whenever it wants to, since both are held between pulses.

## Timing
- Reset values: `level = 0`, `level_valid = 0`, `peak = 0`, `hold_cnt = 0`, `acc = 0`, `sample_cnt = 0`, state = ACC.
- Reset mid-window discards the partial sum. The first window after reset starts with the first `sample_valid` seen after reset deasserts.
- Latency: `level_valid` is high in the cycle immediately after the cycle in which the window's last sample is accepted. `level` and `peak` change in that same cycle.
- Throughput: one sample per cycle is sustained indefinitely, including across window boundaries.
- `level_valid` is never high on two consecutive cycles unless `2^LOG2_WIN == 1`, which is illegal.
- Arithmetic:
  - All values are unsigned.
  - Saturation of `level` applies only when `LOG2_WIN + 12 > 20`.
  - The decay subtraction cannot underflow.

## Structure
- Shared package `audio_pkg`:
  - SAMPLE_W = 12
  - MIC_MID = 12'd2048
  - LEVEL_W = 20
  - LEVEL_MAX = 20'hFFFFF
- Sub-module `peak_hold_decay` holds the `peak` and `hold_cnt` registers and the update rule.
  - Inputs: clk, reset, `upd` (the PUB strobe), `L`.
  - Parameters: HOLD_WINDOWS, DECAY_SHIFT.
- The top level holds the magnitude calculation, accumulator, counter, two-state FSM and saturation.

## Test plan
1. Defaults; 256 consecutive samples of 2048 → one `level_valid` one cycle after the 256th sample; `level = 0`, `peak = 0`.
2. Defaults; 256 samples alternating 1948 and 2148 → `level = 25600`, `peak = 25600`. The next window, sent back-to-back with no gap and all samples 0, gives `level = 524288`, `peak = 524288`, and confirms no sample is dropped at the boundary.
3. Decay. After the peak reaches 25600, send windows of 2048:
   - windows 1–4: `peak = 25600`
   - window 5: `peak = 22400`
   - window 6: `peak = 19600`
   - each of these windows gives `level = 0`
4. Assert reset after 100 samples of 0 → all outputs 0 on the next cycle. Then 256 samples of 2148 → `level = 25600`, not including any of the discarded samples.
5. LOG2_WIN = 10; 1024 samples of 0 → the raw sum is 2097152, so `level = 1048575` and `peak = 1048575`.
6. Defaults; 256 samples of 2148 delivered with random 0–3 idle cycles between them → `level = 25600`; `level_valid` pulses exactly once, one cycle after the last sample.
